// File: rtl/prom_word_loader_pkg.sv
// prom_word_loader_pkg
// Shared constants for the PROM word loader and its testbench: FSM state
// encoding, byte/address/checksum widths and an index-width helper.
package prom_word_loader_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned PROM_AW    = 9;   // 512 x 8 PROM
    localparam int unsigned CHECKSUM_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Width of an index over n items; never zero so single-word loads still elaborate.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prom_word_loader_if.sv
// prom_word_loader_if
// Bundles the loader's control, PROM and word-output signals.
//   master : the loader (drives busy/done, PROM address/enable, word outputs)
//   slave  : the environment (drives start, prom_data, word_ready)
// Signals:
//   start, busy, done           - load request / in progress / complete
//   prom_addr, prom_ce_n        - PROM byte address and active-low enable
//   prom_data                   - PROM read data
//   word_valid, word_ready      - output word handshake
//   word_data, word_addr        - assembled word and its index
//   checksum                    - 16-bit sum of bytes read in this/last load
interface prom_word_loader_if #(
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned WORD_COUNT     = 128
) ();
    import prom_word_loader_pkg::*;

    localparam int unsigned WORD_W = BYTE_W * BYTES_PER_WORD;
    localparam int unsigned WIDX_W = idx_width(WORD_COUNT);

    logic                  start;
    logic                  busy;
    logic                  done;
    logic [PROM_AW-1:0]    prom_addr;
    logic                  prom_ce_n;
    logic [BYTE_W-1:0]     prom_data;
    logic                  word_valid;
    logic                  word_ready;
    logic [WORD_W-1:0]     word_data;
    logic [WIDX_W-1:0]     word_addr;
    logic [CHECKSUM_W-1:0] checksum;

    modport master (
        input  start, prom_data, word_ready,
        output busy, done, prom_addr, prom_ce_n, word_valid, word_data, word_addr, checksum
    );

    modport slave (
        output start, prom_data, word_ready,
        input  busy, done, prom_addr, prom_ce_n, word_valid, word_data, word_addr, checksum
    );

endinterface

// File: rtl/prom_byte_packer.sv
// prom_byte_packer
// Shifts PROM bytes into a word, little-endian: the first byte shifted in
// ends up in bits [7:0] once BYTES_PER_WORD bytes have been loaded.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   clear       - synchronous clear of the word
//   shift       - load prom_byte this cycle
//   prom_byte   - byte to shift in
//   word        - packed word
module prom_byte_packer
    import prom_word_loader_pkg::*;
#(
    parameter int unsigned BYTES_PER_WORD = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic                             shift,
    input  logic [BYTE_W-1:0]                prom_byte,
    output logic [BYTE_W*BYTES_PER_WORD-1:0] word
);

    localparam int unsigned WORD_W = BYTE_W * BYTES_PER_WORD;

    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_d;

    // New bytes enter at the top and move down, so byte 0 finishes at the bottom.
    if (BYTES_PER_WORD == 1) begin : g_single
        assign word_d = prom_byte;
    end else begin : g_multi
        assign word_d = {prom_byte, word_q[WORD_W-1:BYTE_W]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
        end else if (clear) begin
            word_q <= '0;
        end else if (shift) begin
            word_q <= word_d;
        end
    end

    assign word = word_q;

endmodule

// File: rtl/prom_word_loader.sv
// prom_word_loader
// Reads BYTES_PER_WORD*WORD_COUNT bytes from a 512x8 PROM, packs them into
// words and hands each word downstream over a valid/ready handshake, keeping
// a running 16-bit checksum of every byte read.
// Ports:
//   clk    - clock, all state changes on its rising edge
//   reset  - asynchronous active-high reset
//   bus    - prom_word_loader_if.master (control, PROM and word signals)
module prom_word_loader
    import prom_word_loader_pkg::*;
#(
    parameter int unsigned ROM_WAIT       = 1,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned WORD_COUNT     = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    prom_word_loader_if.master    bus
);

    localparam int unsigned WIDX_W = idx_width(WORD_COUNT);
    localparam int unsigned WORD_W = BYTE_W * BYTES_PER_WORD;

    localparam logic [3:0]        WAIT_LAST = 4'(ROM_WAIT);
    localparam logic [2:0]        BYTE_LAST = 3'(BYTES_PER_WORD - 1);
    localparam logic [WIDX_W-1:0] WORD_LAST = WIDX_W'(WORD_COUNT - 1);

    state_t                state_q, state_d;
    logic [3:0]            wait_q, wait_d;
    logic [2:0]            byte_q, byte_d;
    logic [WIDX_W-1:0]     word_q, word_d;
    logic [CHECKSUM_W-1:0] csum_q, csum_d;
    logic                  done_q, done_d;
    logic                  sample;
    logic                  clear;
    logic [WORD_W-1:0]     packed_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        byte_d  = byte_q;
        word_d  = word_q;
        csum_d  = csum_q;
        done_d  = done_q;
        sample  = 1'b0;
        clear   = 1'b0;

        unique case (state_q)
            // DONE lasts one cycle and behaves like IDLE, so start is never lost.
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = FETCH;
                    wait_d  = '0;
                    byte_d  = '0;
                    word_d  = '0;
                    csum_d  = '0;
                    done_d  = 1'b0;
                    clear   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            // wait_q==0 is the address setup cycle; it then runs 1..ROM_WAIT and
            // the byte is taken on the ROM_WAIT edge: ROM_WAIT+1 cycles per byte.
            FETCH: begin
                if (wait_q == WAIT_LAST) begin
                    sample = 1'b1;
                    csum_d = csum_q + CHECKSUM_W'(bus.prom_data);
                    wait_d = '0;
                    if (byte_q == BYTE_LAST) begin
                        byte_d  = '0;
                        state_d = PRESENT;
                    end else begin
                        byte_d = byte_q + 3'd1;
                    end
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end

            PRESENT: begin
                if (bus.word_ready) begin
                    if (word_q == WORD_LAST) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        word_d  = word_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    prom_byte_packer #(
        .BYTES_PER_WORD (BYTES_PER_WORD)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .shift     (sample),
        .prom_byte (bus.prom_data),
        .word      (packed_word)
    );

    // Address is derived from the counters, so it only moves when byte_q/word_q do.
    assign bus.prom_addr  = PROM_AW'(word_q) * PROM_AW'(BYTES_PER_WORD) + PROM_AW'(byte_q);
    assign bus.prom_ce_n  = (state_q != FETCH);
    assign bus.word_valid = (state_q == PRESENT);
    assign bus.busy       = (state_q == FETCH) || (state_q == PRESENT);
    assign bus.done       = done_q;
    assign bus.word_data  = packed_word;
    assign bus.word_addr  = word_q;
    assign bus.checksum   = csum_q;

endmodule

// File: tb/tb_prom_word_loader.sv
module tb_prom_word_loader;
    import prom_word_loader_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [7:0]  rom_a [512];
    logic [7:0]  rom_b [2];
    logic [31:0] got_w0, got_w127, got_stall;

    prom_word_loader_if #(.BYTES_PER_WORD(4), .WORD_COUNT(128)) bus_a ();
    prom_word_loader_if #(.BYTES_PER_WORD(1), .WORD_COUNT(2))   bus_b ();

    // PROM models; drive a junk pattern while disabled so any stray sample shows up.
    assign bus_a.prom_data = bus_a.prom_ce_n ? 8'hEE : rom_a[bus_a.prom_addr];
    assign bus_b.prom_data = bus_b.prom_ce_n ? 8'hEE : rom_b[bus_b.prom_addr[0]];

    prom_word_loader #(
        .ROM_WAIT       (1),
        .BYTES_PER_WORD (4),
        .WORD_COUNT     (128)
    ) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    prom_word_loader #(
        .ROM_WAIT       (3),
        .BYTES_PER_WORD (1),
        .WORD_COUNT     (2)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: word w is bytes 4w..4w+3 of the PROM, first byte lowest.
    function automatic logic [31:0] exp_word_a(input int w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = rom_a[w*4 + k];
        return r;
    endfunction

    function automatic logic [15:0] exp_sum_a();
        int s = 0;
        for (int i = 0; i < 512; i++) s += int'(rom_a[i]);
        return 16'(s);
    endfunction

    task automatic check_reset_a(input string tag);
        check({tag, "_busy"},  bus_a.busy, 0);
        check({tag, "_done"},  bus_a.done, 0);
        check({tag, "_valid"}, bus_a.word_valid, 0);
        check({tag, "_ce_n"},  bus_a.prom_ce_n, 1);
        check({tag, "_paddr"}, bus_a.prom_addr, 0);
        check({tag, "_wdata"}, bus_a.word_data, 0);
        check({tag, "_waddr"}, bus_a.word_addr, 0);
        check({tag, "_csum"},  bus_a.checksum, 0);
    endtask

    // mode 0: ready always high; 1: stall word 3 for 5 cycles;
    // 2: random ready; 3: extra start pulses while busy. Called at posedge+1.
    task automatic run_load_a(input int mode);
        int widx  = 0;
        int stall = 0;
        int cyc   = 0;
        bus_a.word_ready = 1'b1;
        bus_a.start      = 1'b1;
        @(posedge clk); #1 bus_a.start = 1'b0;
        @(negedge clk);
        check("ld_busy", bus_a.busy, 1);
        check("ld_done_clr", bus_a.done, 0);
        check("ld_csum0", bus_a.checksum, 0);
        check("ld_paddr0", bus_a.prom_addr, 0);
        while (widx < 128 && cyc < 5000) begin
            check("excl_valid_ce", bus_a.word_valid & ~bus_a.prom_ce_n, 0);
            if (bus_a.word_valid) begin
                if (bus_a.word_ready) begin
                    check("word_data", bus_a.word_data, exp_word_a(widx));
                    check("word_addr", bus_a.word_addr, widx);
                    if (widx == 0)   got_w0   = bus_a.word_data;
                    if (widx == 127) got_w127 = bus_a.word_data;
                    widx++;
                end else if (mode == 1) begin
                    check("stall_data", bus_a.word_data, exp_word_a(widx));
                    check("stall_addr", bus_a.word_addr, widx);
                    check("stall_ce_n", bus_a.prom_ce_n, 1);
                    got_stall = bus_a.word_data;
                    stall++;
                end
            end
            @(posedge clk); #1;
            case (mode)
                1:       bus_a.word_ready = !(widx == 3 && stall < 5);
                2:       bus_a.word_ready = 1'($urandom_range(0, 1));
                default: bus_a.word_ready = 1'b1;
            endcase
            bus_a.start = (mode == 3) && (cyc == 10 || cyc == 400);
            cyc++;
            @(negedge clk);
        end
        bus_a.start = 1'b0;
        check("word_count", widx, 128);
        if (mode == 1) check("stall_cycles", stall, 5);
        check("end_done", bus_a.done, 1);
        check("end_busy", bus_a.busy, 0);
        check("end_ce_n", bus_a.prom_ce_n, 1);
        check("end_csum", bus_a.checksum, exp_sum_a());
        @(posedge clk); #1;
        @(negedge clk);
        check("done_held", bus_a.done, 1);
        check("csum_frozen", bus_a.checksum, exp_sum_a());
        @(posedge clk); #1;
    endtask

    initial begin
        int c;
        reset = 1'b1;
        bus_a.start = 1'b0; bus_a.word_ready = 1'b0;
        bus_b.start = 1'b0; bus_b.word_ready = 1'b0;
        for (int i = 0; i < 512; i++) rom_a[i] = 8'(i);
        rom_b[0] = 8'hAA;
        rom_b[1] = 8'h55;

        #12;
        check_reset_a("por");
        check("por_b_busy", bus_b.busy, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("idle_busy", bus_a.busy, 0);
        check("idle_ce_n", bus_a.prom_ce_n, 1);

        // First-word timing with ROM_WAIT=1: two cycles per byte, word after 8.
        @(posedge clk); #1 bus_a.word_ready = 1'b1; bus_a.start = 1'b1;
        @(posedge clk); #1 bus_a.start = 1'b0;
        for (int n = 0; n <= 8; n++) begin
            @(negedge clk);
            if (n < 8) begin
                check("t_paddr", bus_a.prom_addr, n / 2);
                check("t_ce_n", bus_a.prom_ce_n, 0);
                check("t_valid", bus_a.word_valid, 0);
            end else begin
                check("t_valid_hi", bus_a.word_valid, 1);
                check("t_word0", bus_a.word_data, exp_word_a(0));
            end
        end

        // Abandon the load with an asynchronous reset during word 10 fetch.
        c = 0;
        while (c < 2000 && !(bus_a.word_addr == 7'd10 && !bus_a.prom_ce_n)) begin
            @(negedge clk);
            c++;
        end
        check("w10_fetch", (bus_a.word_addr == 7'd10) && !bus_a.prom_ce_n, 1);
        #2 reset = 1'b1;
        #1 check_reset_a("midrst");
        @(posedge clk); #1 reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("post_rst_valid", bus_a.word_valid, 0);
            check("post_rst_ce_n", bus_a.prom_ce_n, 1);
        end
        @(posedge clk); #1;

        run_load_a(0);
        check("lit_word0", got_w0, 32'h03020100);
        check("lit_word127", got_w127, 32'hFFFEFDFC);
        check("lit_csum", bus_a.checksum, 16'hFF00);

        run_load_a(1);
        check("lit_stall_word3", got_stall, 32'h0F0E0D0C);

        check("done_before_restart", bus_a.done, 1);
        run_load_a(3);

        for (int i = 0; i < 512; i++) rom_a[i] = 8'($urandom);
        run_load_a(2);

        // ROM_WAIT=3, one byte per word, two words.
        bus_b.word_ready = 1'b1;
        bus_b.start = 1'b1;
        @(posedge clk); #1 bus_b.start = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (n % 5 < 4) begin
                check("b_ce_n", bus_b.prom_ce_n, 0);
                check("b_paddr", bus_b.prom_addr, n / 5);
                check("b_valid", bus_b.word_valid, 0);
            end else begin
                check("b_valid_hi", bus_b.word_valid, 1);
                check("b_word", bus_b.word_data, rom_b[n / 5]);
                check("b_waddr", bus_b.word_addr, n / 5);
            end
        end
        @(negedge clk);
        check("b_done", bus_b.done, 1);
        check("b_busy", bus_b.busy, 0);
        check("b_csum", bus_b.checksum, 16'(int'(rom_b[0]) + int'(rom_b[1])));
        check("b_csum_lit", bus_b.checksum, 16'h00FF);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/prom_word_loader.md
PROM_WORD_LOADER -- requirements
Module: prom_word_loader

Interface
REQ-001 SHALL have parameter ROM_WAIT, default 1: cycles the PROM address is held with CE_N low before data is sampled (legal 1..15).
REQ-002 SHALL have parameter BYTES_PER_WORD, default 4: PROM bytes packed per output word (legal 1..8).
REQ-003 SHALL have parameter WORD_COUNT, default 128: words per load; BYTES_PER_WORD*WORD_COUNT SHALL be <= 512.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: one-cycle load request.
REQ-007 SHALL have port busy, output, 1: high from accepted start until done.
REQ-008 SHALL have port done, output, 1: load complete; held until the next accepted start.
REQ-009 SHALL have port prom_addr, output, 9: byte address to the 512x8 PROM.
REQ-010 SHALL have port prom_ce_n, output, 1: active-low PROM chip enable.
REQ-011 SHALL have port prom_data, input, 8: PROM data (tri-stated by PROM when CE_N high).
REQ-012 SHALL have port word_valid, output, 1: word_data/word_addr valid.
REQ-013 SHALL have port word_ready, input, 1: downstream accepts the word.
REQ-014 SHALL have port word_data, output, 8*BYTES_PER_WORD: assembled word.
REQ-015 SHALL have port word_addr, output, clog2(WORD_COUNT): index of word_data.
REQ-016 SHALL have port checksum, output, 16: modulo-2^16 sum of all bytes read in current/last load.

Function
REQ-017 SHALL implement states IDLE, FETCH, PRESENT, DONE.
REQ-018 IDLE: start=1 -> FETCH; byte counter, word index, checksum cleared; done cleared; busy set next cycle.
REQ-019 FETCH: prom_ce_n=0, prom_addr=word_index*BYTES_PER_WORD+byte_index; wait counter runs 1..ROM_WAIT; prom_data sampled on the edge where counter equals ROM_WAIT.
REQ-020 Each byte SHALL cost exactly ROM_WAIT+1 cycles in FETCH; prom_addr SHALL change only at a byte boundary.
REQ-021 Byte k of a word (k=0 first read) SHALL occupy word_data[8k+7:8k] (little-endian packing).
REQ-022 Each sampled byte SHALL be zero-extended and added to checksum, wrapping at 2^16.
REQ-023 After the last byte of a word: -> PRESENT, prom_ce_n=1, word_valid=1.
REQ-024 PRESENT: word_data and word_addr SHALL stay stable while word_valid=1 and word_ready=0; no PROM access (no prefetch).
REQ-025 PRESENT with word_ready=1: word accepted; if word_index=WORD_COUNT-1 -> DONE, else word_index+1 and -> FETCH next cycle.
REQ-026 DONE: done=1, busy=0, prom_ce_n=1, checksum frozen; returns to IDLE same cycle so start is accepted next.
REQ-027 start while busy SHALL be ignored.
REQ-028 word_valid SHALL never be high outside PRESENT; prom_ce_n SHALL be low only in FETCH.

Reset
REQ-029 reset=1 SHALL asynchronously force IDLE, busy=0, done=0, word_valid=0, prom_ce_n=1, prom_addr=0, word_data=0, word_addr=0, checksum=0.
REQ-030 reset mid-load SHALL abandon the load; no partial word SHALL be presented after release.

Structure
REQ-031 State encodings and the checksum width SHALL live in a shared constants include used by the loader and its bench.
REQ-032 Byte packing (shift-in, little-endian) MAY be a sub-module prom_byte_packer; the FSM and counters stay in prom_word_loader.

Verification
REQ-033 PROM bytes = address[7:0], defaults, word_ready=1: word 0 = 0x03020100, word 127 = 0xFFFEFDFC, 128 words, checksum = 0xFF00.
REQ-034 ROM_WAIT=1: start at cycle 0 -> word_valid first high 8 cycles after FETCH entry; prom_addr steps 0,1,2,3 every 2 cycles.
REQ-035 word_ready low 5 cycles on word 3: word_data 0x0F0E0D0C and word_addr 3 stable; prom_ce_n=1 throughout.
REQ-036 reset asserted during word 10 FETCH: all outputs to REQ-029 values immediately; next start restarts at prom_addr 0, checksum 0.
REQ-037 start pulsed while busy: no restart, word sequence unchanged; after done, start begins new load with done cleared.
REQ-038 ROM_WAIT=3, BYTES_PER_WORD=1, WORD_COUNT=2, bytes 0xAA,0x55: words 0xAA,0x55, checksum 0x00FF, 4 cycles per byte.
